alu_arbiter: RTL

Shares the single 64-bit `alu` datapath between two requesters, e.g. the main execute path and an address/compare helper. It arbitrates round-robin with a valid/ready handshake and registers the selected operands and opcode. It runs one ALU operation and returns the registered result and zero flag to the requester that issued it. The `alu` instance is internal; requesters never drive it directly.

---
 rtl/alu_arbiter.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Shares one 64-bit ALU between two requesters. A round-robin arbiter grants
//   one request at a time through a valid/ready handshake. The grant latches
//   the operands, the opcode and the owner id. The ALU runs on those registered
//   values for one EXEC cycle. The result and zero flag are then registered
//   into the owner's response registers, and that owner's response valid is
//   pulsed for exactly one cycle.
//
// Ports:
//   clk                 in   1   single clock, rising edge
//   reset               in   1   synchronous, active-high
//   req0_valid          in   1   requester 0 has an operation pending
//   req0_ready          out  1   requester 0 granted this cycle
//   req0_a, req0_b      in  64   operands from requester 0
//   req0_op             in   4   ALUControl code from requester 0
//   req1_*                       same set for requester 1
//   resp0_valid         out  1   one-cycle pulse, result for requester 0
//   resp0_result        out 64   registered ALU result
//   resp0_zero          out  1   registered ALU zero flag
//   resp1_*                      same set for requester 1
//
// Also contains the combinational `alu` used internally.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// alu
//
// Purpose:
//   Purely combinational 64-bit ALU driven by a 4-bit ALUControl code.
//   Arithmetic wraps modulo 2^64 and there is no carry or overflow output.
//   An undefined code yields result 0, so zero reads 1.
//
// Ports:
//   a, b     in  64   operands
//   op       in   4   ALUControl code
//   result   out 64   operation result
//   zero     out  1   high iff result == 0
// -----------------------------------------------------------------------------
module alu (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [3:0]  op,
  output logic [63:0] result,
  output logic        zero
);

  localparam logic [3:0] A_AND_B      = 4'b0000;
  localparam logic [3:0] A_OR_B       = 4'b0001;
  localparam logic [3:0] A_PLUS_B     = 4'b0010;
  localparam logic [3:0] A_MINUS_B    = 4'b0110;
  localparam logic [3:0] PASS_INPUT_B = 4'b0111;
  localparam logic [3:0] A_NOR_B      = 4'b1100;

  always_comb begin
    result = '0;
    case (op)
      A_AND_B:      result = a & b;
      A_OR_B:       result = a | b;
      A_PLUS_B:     result = a + b;
      A_MINUS_B:    result = a - b;
      PASS_INPUT_B: result = b;
      A_NOR_B:      result = ~(a | b);
      default:      result = '0;
    endcase
  end

  assign zero = (result == 64'd0);

endmodule

module alu_arbiter (
  input  logic        clk,
  input  logic        reset,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  input  logic [3:0]  req0_op,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  input  logic [3:0]  req1_op,

  output logic        resp0_valid,
  output logic [63:0] resp0_result,
  output logic        resp0_zero,

  output logic        resp1_valid,
  output logic [63:0] resp1_result,
  output logic        resp1_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  // Requester id that won the most recent handshake. Its reset value is 1,
  // so requester 0 wins the first tie.
  logic        last_grant_reg;

  // Operands latched at the handshake edge. The requester may change its
  // inputs after the grant without disturbing the in-flight operation.
  logic [63:0] a_reg;
  logic [63:0] b_reg;
  logic [3:0]  op_reg;
  logic        owner_reg;

  logic [1:0]  valid_vec;
  logic [1:0]  ready_vec;
  logic        can_accept;
  logic        accept;
  logic        accept_id;

  logic [63:0] sel_a;
  logic [63:0] sel_b;
  logic [3:0]  sel_op;

  logic [63:0] alu_result;
  logic        alu_zero;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign valid_vec = {req1_valid, req0_valid};

  // Accepts happen in IDLE and DONE only. Reset masks the readies
  // combinationally, so no handshake can complete on the reset edge.
  assign can_accept = (state_reg != ST_EXEC) && !reset;

  // A requester wins if it is the only one valid, or if both are valid and it
  // was not the last one granted. The two terms are mutually exclusive, so at
  // most one ready can be high in any cycle.
  assign ready_vec[0] = can_accept && valid_vec[0] && (!valid_vec[1] ||  last_grant_reg);
  assign ready_vec[1] = can_accept && valid_vec[1] && (!valid_vec[0] || !last_grant_reg);

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];

  assign accept    = |ready_vec;
  assign accept_id = ready_vec[1];

  assign sel_a  = accept_id ? req1_a  : req0_a;
  assign sel_b  = accept_id ? req1_b  : req0_b;
  assign sel_op = accept_id ? req1_op : req0_op;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_next = ST_DONE;
      end
      ST_DONE: begin
        // The response pulse is visible this cycle. A new accept overlaps it,
        // which gives one operation per two cycles under load.
        if (accept) begin
          state_next = ST_EXEC;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand latch and round-robin pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= 1'b1;
      a_reg          <= '0;
      b_reg          <= '0;
      op_reg         <= '0;
      owner_reg      <= 1'b0;
    end else if (accept) begin
      last_grant_reg <= accept_id;
      a_reg          <= sel_a;
      b_reg          <= sel_b;
      op_reg         <= sel_op;
      owner_reg      <= accept_id;
    end
  end

  // ---------------------------------------------------------------------------
  // Shared ALU, evaluated on the latched operands during EXEC
  // ---------------------------------------------------------------------------
  alu u_alu (
    .a      (a_reg),
    .b      (b_reg),
    .op     (op_reg),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // ---------------------------------------------------------------------------
  // Per-requester response registers
  //
  // Only the owner's registers load at the end of EXEC. The valid bit clears
  // on every other edge, so it is high for exactly the DONE cycle. Result and
  // zero hold their value until that requester's next completion. Reset takes
  // priority over the EXEC load, so an operation interrupted by reset never
  // produces a pulse.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    localparam logic ID = 1'(gi);

    logic        resp_valid_reg;
    logic [63:0] resp_result_reg;
    logic        resp_zero_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        resp_valid_reg  <= 1'b0;
        resp_result_reg <= '0;
        resp_zero_reg   <= 1'b0;
      end else begin
        resp_valid_reg <= 1'b0;
        if ((state_reg == ST_EXEC) && (owner_reg == ID)) begin
          resp_valid_reg  <= 1'b1;
          resp_result_reg <= alu_result;
          resp_zero_reg   <= alu_zero;
        end
      end
    end
  end

  assign resp0_valid  = g_resp[0].resp_valid_reg;
  assign resp0_result = g_resp[0].resp_result_reg;
  assign resp0_zero   = g_resp[0].resp_zero_reg;

  assign resp1_valid  = g_resp[1].resp_valid_reg;
  assign resp1_result = g_resp[1].resp_result_reg;
  assign resp1_zero   = g_resp[1].resp_zero_reg;

endmodule
